logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 Parameter: WIDTH, 4, bit width of each operand lane and of the result.
REQ-002 Parameter: N_IN, 2, operand lanes per input beat (N_IN >= 2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  input beat valid.
REQ-006 Port: in_ready  output  1  block can accept an input beat.
REQ-007 Port: in_data  input  N_IN*WIDTH  operand lanes; lane k = in_data[k*WIDTH +: WIDTH].
REQ-008 Port: in_op  input  3  operation: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 reserved.
REQ-009 Port: in_last  input  1  final beat of a packet.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_data  output  WIDTH  packet result.
REQ-013 Port: out_beats  output  8  beats in packet, saturating at 255.
REQ-014 Port: out_err  output  1  packet used a reserved op.

Function
REQ-015 An input beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-016 States SHALL be IDLE (no partial packet), ACCUM (partial packet held), HOLD (result presented).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD.
REQ-018 Op SHALL be latched from in_op on the first beat of a packet; in_op on later beats SHALL be ignored.
REQ-019 Base op SHALL be AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR; bitwise across all N_IN lanes of every beat of the packet.
REQ-020 First beat SHALL load the accumulator with the base-op reduction of its lanes; each later beat SHALL combine accumulator with its lane reduction using the base op.
REQ-021 NAND/NOR/XNOR SHALL invert the final accumulator once, at result time, not per beat.
REQ-022 Accepted beat with in_last=0: IDLE->ACCUM or ACCUM->ACCUM.
REQ-023 Accepted beat with in_last=1: IDLE/ACCUM->HOLD; out_valid, out_data, out_beats, out_err registered on that edge (latency 1 cycle from last-beat acceptance).
REQ-024 HOLD with out_ready=1 SHALL go to IDLE on the next edge, dropping out_valid; HOLD with out_ready=0 SHALL hold out_valid and all outputs stable.
REQ-025 Beat counter SHALL count accepted beats including the last, saturating at 255.
REQ-026 Reserved op: out_err=1, out_data=0, out_beats still valid; packet framing unaffected.
REQ-027 out_data/out_beats/out_err SHALL change only on entry to HOLD; unchanged in IDLE/ACCUM.
REQ-028 in_valid=0 in ACCUM SHALL hold accumulator, count and state.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_data=0, out_beats=0, out_err=0, accumulator and count 0, in_ready=1 after release.
REQ-030 Reset mid-packet or in HOLD SHALL discard the partial packet/result; no output beat after release.

Verification (WIDTH=4, N_IN=2)
REQ-031 Single beat AND, lanes 4'hC,4'hA, in_last=1 -> next cycle out_valid=1, out_data=4'h8, out_beats=1, out_err=0.
REQ-032 Three-beat XNOR: beats {1,2},{4,0},{8,0}, in_op changed to 000 on beats 2-3 -> out_data=4'h0 (~4'hF), out_beats=3.
REQ-033 NAND beat {F,F} with out_ready=0 for 5 cycles -> out_valid and out_data=4'h0 stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 OR packet, 2 beats accepted, rst_n pulsed low -> outputs 0 immediately; new single-beat OR {3,4} -> out_data=4'h7, out_beats=1.
REQ-035 in_op=3'b110 single beat {F,F} -> out_err=1, out_data=0, out_beats=1.
REQ-036 300-beat AND packet of {F,F} -> out_beats=255, out_data=4'hF.

Source files
------------

// File: rtl/logic_gate_unit.sv
// Packet-wide bitwise logic reduction over N_IN lanes per beat.
// Result, beat count and reserved-op flag are held until downstream takes them.
module logic_gate_unit #(
  parameter int WIDTH = 4,
  parameter int N_IN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [2:0]            in_op,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [7:0]            out_beats,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    B_AND,
    B_OR,
    B_XOR
  } base_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       beats_q, beats_d;
  logic             err_q, err_d;

  logic [2:0]       op_eff;
  base_t            base;
  logic             fire;
  logic             first;
  logic             rsvd;
  logic             inv;
  logic [WIDTH-1:0] red;
  logic [WIDTH-1:0] acc_nx;
  logic [7:0]       cnt_nx;
  logic [WIDTH-1:0] res;

  function automatic logic [WIDTH-1:0] apply(
    input base_t            b,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    unique case (b)
      B_AND:   r = x & y;
      B_OR:    r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_beats = beats_q;
  assign out_err   = err_q;

  assign fire   = in_valid && in_ready;
  assign first  = (state_q == IDLE);
  assign op_eff = first ? in_op : op_q;
  assign rsvd   = (op_eff[2:1] == 2'b11);
  assign inv    = (op_eff == 3'd3) ||
                  (op_eff == 3'd4) ||
                  (op_eff == 3'd5);

  // Decode the base operation shared by a gate and its inverse
  always_comb begin
    base = B_XOR;
    unique case (1'b1)
      (op_eff == 3'd0) || (op_eff == 3'd3): base = B_AND;
      (op_eff == 3'd1) || (op_eff == 3'd4): base = B_OR;
      default:                              base = B_XOR;
    endcase
  end

  // Reduce this beat's lanes and fold into the running accumulator
  always_comb begin
    red = in_data[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) begin
      red = apply(base, red, in_data[k*WIDTH +: WIDTH]);
    end
    acc_nx = first ? red : apply(base, acc_q, red);
    cnt_nx = first ? 8'd1 :
             (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  // Final inversion applies once to the whole packet
  always_comb begin
    res = acc_nx;
    unique case (1'b1)
      rsvd:    res = '0;
      inv:     res = ~acc_nx;
      default: res = acc_nx;
    endcase
  end

  // Next-state and output-register update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    beats_d = beats_q;
    err_d   = err_q;
    if (fire) begin
      op_d  = op_eff;
      acc_d = acc_nx;
      cnt_d = cnt_nx;
      if (in_last) begin
        state_d = HOLD;
        acc_d   = '0;
        cnt_d   = '0;
        data_d  = res;
        beats_d = cnt_nx;
        err_d   = rsvd;
      end else begin
        state_d = ACCUM;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit.
// Expected packet results are queued at stimulus time and popped at output.
module tb_logic_gate_unit;

  localparam int WIDTH = 4;
  localparam int N_IN  = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [7:0]       beats;
    logic             err;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [2:0]            in_op;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [7:0]            out_beats;
  logic                  out_err;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic             m_first;
  logic [2:0]       m_op;
  logic [WIDTH-1:0] m_acc;
  logic [7:0]       m_cnt;

  logic_gate_unit #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] gate(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    if (op == 3'd0 || op == 3'd3) return a & b;
    if (op == 3'd1 || op == 3'd4) return a | b;
    return a ^ b;
  endfunction

  task automatic model_reset();
    m_first = 1'b1;
    m_acc   = '0;
    m_cnt   = '0;
  endtask

  task automatic beat(input logic [WIDTH-1:0] l0,
                      input logic [WIDTH-1:0] l1,
                      input logic [2:0] op,
                      input logic last);
    logic [WIDTH-1:0] r;
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {l1, l0};
    in_op    = op;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (m_first) m_op = op;
    r = gate(m_op, l0, l1);
    m_acc = m_first ? r : gate(m_op, m_acc, r);
    m_cnt = m_first ? 8'd1 : (m_cnt == 8'hFF ? m_cnt : m_cnt + 8'd1);
    m_first = 1'b0;
    if (last) begin
      e.beats = m_cnt;
      e.err   = (m_op >= 3'd6);
      if (e.err) e.data = '0;
      else if (m_op >= 3'd3) e.data = ~m_acc;
      else e.data = m_acc;
      sb.push_back(e);
      model_reset();
    end
  endtask

  task automatic result(input string tag, input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"},  out_data,  e.data);
    chk({tag, "_beats"}, out_beats, e.beats);
    chk({tag, "_err"},   out_err,   e.err);
    chk({tag, "_rdy0"},  in_ready,  0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hvalid"}, out_valid, 1);
      chk({tag, "_hdata"},  out_data,  e.data);
      chk({tag, "_hrdy"},   in_ready,  0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 0);
    chk({tag, "_rdy1"}, in_ready,  1);
    chk({tag, "_keep"}, out_data,  e.data);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    m_op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_beats", out_beats, 0);
    chk("rst_err",   out_err,   0);
    chk("rst_ready", in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;

    beat(4'hC, 4'hA, 3'b000, 1'b1);
    chk("and_fixed", out_data, 4'h8);
    result("and1", 0);

    beat(4'h1, 4'h0, 3'b001, 1'b0);
    beat(4'h2, 4'h0, 3'b001, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data",  out_data,  0);
    chk("mrst_beats", out_beats, 0);
    chk("mrst_rdy",   in_ready,  1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_nobeat", out_valid, 0);
    beat(4'h3, 4'h4, 3'b001, 1'b1);
    chk("or_fixed", out_data, 4'h7);
    result("or1", 0);

    beat(4'h1, 4'h2, 3'b101, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_rdy",   in_ready,  1);
    chk("gap_valid", out_valid, 0);
    beat(4'h4, 4'h0, 3'b000, 1'b0);
    beat(4'h8, 4'h0, 3'b000, 1'b1);
    chk("xnor_fixed", out_data, 4'h0);
    result("xnor3", 0);

    beat(4'hF, 4'hF, 3'b011, 1'b1);
    result("nand_hold", 5);

    beat(4'hF, 4'hF, 3'b110, 1'b1);
    chk("rsvd_fixed", out_err, 1);
    result("rsvd", 1);

    beat(4'h5, 4'h6, 3'b100, 1'b1);
    result("nor", 0);

    for (int i = 0; i < 299; i++) beat(4'hF, 4'hF, 3'b000, 1'b0);
    beat(4'hF, 4'hF, 3'b000, 1'b1);
    chk("sat_fixed", out_beats, 8'd255);
    result("sat300", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
